// File: rtl/result_serializer_if.sv
// Result-in / word-out handshake bundle for the result serializer.
// The slave modport is the serializer's view; master is the driving environment.
interface result_serializer_if #(
    parameter int DATA_W = 256,
    parameter int WORD_W = 32
) ();
    logic              in_valid;
    logic [DATA_W-1:0] Q;
    logic [WORD_W-1:0] out_word;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport slave (
        input  in_valid, Q, out_ready,
        output out_word, out_valid, out_last
    );

    modport master (
        output in_valid, Q, out_ready,
        input  out_word, out_valid, out_last
    );
endinterface

// File: rtl/result_serializer.sv
// Buffers multiplier results in a FIFO and streams each one as WORDS words,
// most-significant first, over ready/valid. Results arriving into a full FIFO are dropped.
module result_serializer #(
    parameter int DATA_W = 256,
    parameter int WORD_W = 32,
    parameter int WORDS  = 8,
    parameter int DEPTH  = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    result_serializer_if.slave           bus,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(WORDS);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [IW-1:0] LAST_C  = IW'(WORDS-1);

    typedef enum logic {IDLE, SEND} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              overflow_q, overflow_d;
    logic              full_q, full_d;
    logic              push, pop, hs, not_empty;

    always_comb begin
        hs        = out_valid_q & bus.out_ready;
        not_empty = (count_q != '0);
        pop       = 1'b0;
        state_d   = state_q;
        sr_d      = sr_q;
        idx_d     = idx_q;
        case (state_q)
            IDLE: if (not_empty) begin
                pop     = 1'b1;
                state_d = SEND;
            end
            SEND: if (hs) begin
                if (idx_q != LAST_C) begin
                    sr_d  = sr_q << WORD_W;
                    idx_d = idx_q + IW'(1);
                end else if (not_empty) begin
                    pop = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            sr_d  = mem[rd_ptr_q];
            idx_d = '0;
        end
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        push        = bus.in_valid & ((count_q != DEPTH_C) | pop);
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q + CW'(push) - CW'(pop);
        full_d      = (count_d == DEPTH_C);
        overflow_d  = overflow_q | (bus.in_valid & ~push);
        out_valid_d = (state_d == SEND);
        out_last_d  = (state_d == SEND) && (idx_d == LAST_C);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sr_q        <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            sr_q        <= sr_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
            full_q      <= full_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && push) mem[wr_ptr_q] <= bus.Q;
    end

    // The word on the bus is always the top of the shift register; it holds in IDLE.
    assign bus.out_word  = sr_q[DATA_W-1 -: WORD_W];
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign count         = count_q;
    assign full          = full_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer: expected words are queued at push time
// and compared against the words captured on each output handshake.
module tb_result_serializer;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] count;
    logic       full, overflow;

    result_serializer_if #(.DATA_W(256), .WORD_W(32)) bus ();

    result_serializer #(.DATA_W(256), .WORD_W(32), .WORDS(8), .DEPTH(16)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .count(count), .full(full), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [31:0] got_w[$];
    bit          got_l[$];
    int          got_c[$];
    logic [31:0] exp_w[$];

    always @(posedge clock) cyc++;

    // A word transfers at the next rising edge when valid&ready hold mid-cycle.
    always @(negedge clock) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            got_w.push_back(bus.out_word);
            got_l.push_back(bus.out_last);
            got_c.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [255:0] rand_q();
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    function automatic logic [31:0] word_of(input logic [255:0] q, input int w);
        return q[255-32*w -: 32];
    endfunction

    task automatic push_exp(input logic [255:0] q);
        for (int w = 0; w < 8; w++) exp_w.push_back(word_of(q, w));
    endtask

    task automatic wait_got(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (got_w.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        got_w.delete(); got_l.delete(); got_c.delete(); exp_w.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
        checks++; if (bus.out_word !== 32'h0) begin errors++; $display("FAIL reset_out_word got %h want 0", bus.out_word); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if ({full, overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {full, overflow}); end
    endtask

    task automatic test_single();
        logic [255:0] q = 256'h7aa790fb62f949ed3b4f3fce2d1b3c63c9f429ebabbbc258df59d4a4076784e0;
        logic [31:0]  ref_w [8] = '{32'h7aa790fb, 32'h62f949ed, 32'h3b4f3fce, 32'h2d1b3c63,
                                   32'hc9f429eb, 32'habbbc258, 32'hdf59d4a4, 32'h076784e0};
        bit ok;
        do_reset();
        bus.out_ready = 1'b1;
        bus.Q = q; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || count !== 5'd1) begin errors++; $display("FAIL single_k got valid=%b count=%0d want 0/1", bus.out_valid, count); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h7aa790fb) begin errors++; $display("FAIL single_latency got valid=%b word=%h want 1/7aa790fb", bus.out_valid, bus.out_word); end
        wait_got(8, ok);
        repeat (10) tick();
        checks++; if (!ok || got_w.size() != 8) begin errors++; $display("FAIL single_count got %0d words want 8", got_w.size()); end
        for (int i = 0; i < 8 && i < got_w.size(); i++) begin
            checks++;
            if (got_w[i] !== ref_w[i] || got_l[i] !== (i == 7) || got_c[i] != got_c[0] + i) begin
                errors++; $display("FAIL single_word%0d got %h last=%b cyc=%0d want %h last=%b cyc=%0d",
                                   i, got_w[i], got_l[i], got_c[i], ref_w[i], (i == 7), got_c[0] + i);
            end
        end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_idle got valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        logic [255:0] q = 256'h7aa790fb62f949ed3b4f3fce2d1b3c63c9f429ebabbbc258df59d4a4076784e0;
        logic [31:0] pw;
        logic pv, pr;
        int i = 0;
        do_reset();
        bus.out_ready = 1'b1;
        bus.Q = q; bus.in_valid = 1'b1; push_exp(q);
        tick();
        bus.in_valid = 1'b0;
        while (got_w.size() < 8 && i < 100) begin
            pw = bus.out_word; pv = bus.out_valid; pr = bus.out_ready;
            tick();
            if (pv && !pr) begin
                checks++;
                if (bus.out_word !== pw || bus.out_valid !== 1'b1) begin
                    errors++; $display("FAIL bp_hold got %h valid=%b want %h valid=1", bus.out_word, bus.out_valid, pw);
                end
            end
            i++;
            bus.out_ready = ((i % 4) == 0) || ((i % 4) == 3);
        end
        bus.out_ready = 1'b1;
        repeat (12) tick();
        checks++; if (got_w.size() != 8) begin errors++; $display("FAIL bp_count got %0d words want 8", got_w.size()); end
        for (int k = 0; k < 8 && k < got_w.size(); k++) begin
            checks++;
            if (got_w[k] !== exp_w[k]) begin errors++; $display("FAIL bp_word%0d got %h want %h", k, got_w[k], exp_w[k]); end
        end
    endtask

    task automatic test_burst();
        int peak = 0;
        bit ok;
        logic [255:0] q;
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            q = rand_q();
            bus.Q = q; bus.in_valid = 1'b1; push_exp(q);
            tick();
            if (int'(count) > peak) peak = int'(count);
        end
        bus.in_valid = 1'b0;
        wait_got(80, ok);
        repeat (10) tick();
        checks++; if (!ok || got_w.size() != 80) begin errors++; $display("FAIL burst_count got %0d words want 80", got_w.size()); end
        checks++; if (peak > 8) begin errors++; $display("FAIL burst_peak got %0d want <=8", peak); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL burst_overflow got %b want 0", overflow); end
        for (int k = 0; k < 80 && k < got_w.size(); k++) begin
            checks++;
            if (got_w[k] !== exp_w[k] || got_c[k] != got_c[0] + k || got_l[k] !== ((k % 8) == 7)) begin
                errors++; $display("FAIL burst_word%0d got %h cyc=%0d want %h cyc=%0d", k, got_w[k], got_c[k], exp_w[k], got_c[0] + k);
            end
        end
    endtask

    task automatic test_overflow();
        logic [255:0] qs [20];
        bit ok;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            qs[i] = rand_q();
            bus.Q = qs[i]; bus.in_valid = 1'b1;
            if (i < 17) push_exp(qs[i]);
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_state got count=%0d full=%b ovf=%b want 16/1/1", count, full, overflow); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_word !== word_of(qs[0], 0)) begin errors++; $display("FAIL ovf_sr got valid=%b word=%h want 1/%h", bus.out_valid, bus.out_word, word_of(qs[0], 0)); end
        bus.out_ready = 1'b1;
        wait_got(136, ok);
        repeat (30) tick();
        checks++; if (!ok || got_w.size() != 136) begin errors++; $display("FAIL ovf_count got %0d words want 136", got_w.size()); end
        for (int k = 0; k < 136 && k < got_w.size(); k++) begin
            checks++;
            if (got_w[k] !== exp_w[k]) begin errors++; $display("FAIL ovf_word%0d got %h want %h", k, got_w[k], exp_w[k]); end
        end
        checks++; if (count !== 5'd0 || full !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_after got count=%0d full=%b ovf=%b want 0/0/1", count, full, overflow); end
    endtask

    task automatic test_full_push();
        logic [255:0] q;
        bit ok;
        int n = 0;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            q = rand_q();
            bus.Q = q; bus.in_valid = 1'b1; push_exp(q);
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL fullpush_pre got count=%0d full=%b want 16/1", count, full); end
        bus.out_ready = 1'b1;
        while (bus.out_last !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL fullpush_last got %b want 1", bus.out_last); end
        q = rand_q();
        bus.Q = q; bus.in_valid = 1'b1; push_exp(q);
        tick();
        bus.in_valid = 1'b0;
        checks++; if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL fullpush_post got count=%0d ovf=%b full=%b want 16/0/1", count, overflow, full); end
        wait_got(144, ok);
        repeat (20) tick();
        checks++; if (!ok || got_w.size() != 144) begin errors++; $display("FAIL fullpush_count got %0d words want 144", got_w.size()); end
        for (int k = 0; k < 144 && k < got_w.size(); k++) begin
            checks++;
            if (got_w[k] !== exp_w[k]) begin errors++; $display("FAIL fullpush_word%0d got %h want %h", k, got_w[k], exp_w[k]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] q1, q;
        bit ok;
        do_reset();
        q1 = rand_q();
        for (int i = 0; i < 6; i++) begin
            bus.Q = (i == 0) ? q1 : rand_q(); bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL rmid_queued got %0d want 5", count); end
        bus.out_ready = 1'b1;
        repeat (3) tick();
        checks++; if (bus.out_word !== word_of(q1, 3)) begin errors++; $display("FAIL rmid_word3 got %h want %h", bus.out_word, word_of(q1, 3)); end
        bus.out_ready = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b/%b want 0/0", bus.out_valid, bus.out_last); end
        checks++; if (count !== 5'd0 || overflow !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL rmid_count got count=%0d ovf=%b full=%b want 0/0/0", count, overflow, full); end
        checks++; if (bus.out_word !== 32'h0) begin errors++; $display("FAIL rmid_word got %h want 0", bus.out_word); end
        got_w.delete(); got_l.delete(); got_c.delete(); exp_w.delete();
        bus.out_ready = 1'b1;
        q = rand_q();
        bus.Q = q; bus.in_valid = 1'b1; push_exp(q);
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_lat0 got %b want 0", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_word !== word_of(q, 0)) begin errors++; $display("FAIL rmid_lat1 got %b/%h want 1/%h", bus.out_valid, bus.out_word, word_of(q, 0)); end
        wait_got(8, ok);
        repeat (20) tick();
        checks++; if (!ok || got_w.size() != 8) begin errors++; $display("FAIL rmid_count_words got %0d want 8", got_w.size()); end
        for (int k = 0; k < 8 && k < got_w.size(); k++) begin
            checks++;
            if (got_w[k] !== exp_w[k]) begin errors++; $display("FAIL rmid_out%0d got %h want %h", k, got_w[k], exp_w[k]); end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.Q         = '0;
        bus.out_ready = 1'b0;
        tick();
        test_reset();
        test_single();
        test_backpressure();
        test_burst();
        test_overflow();
        test_full_push();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/result_serializer.md
# result_serializer

Downstream stage of the pipelined 256-bit modular multiplier. Captures every `out_valid`/`Q` result the multiplier emits into a result FIFO and streams each result as eight 32-bit words over a ready/valid interface, most-significant word first. The multiplier has no backpressure, so this block absorbs bursts; results that arrive while the FIFO is full are dropped and flagged.

## Interface

Parameters:
- `DATA_W`, default 256: result width; must equal `WORDS*WORD_W`.
- `WORD_W`, default 32: output word width.
- `WORDS`, default 8: words per result.
- `DEPTH`, default 16: FIFO entries (power of two).

Ports (clock and reset first):
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  driven by multiplier `out_valid`.
- `Q`  in  DATA_W  multiplier result; sampled when `in_valid`=1.
- `out_word`  out  WORD_W  current word.
- `out_valid`  out  1  `out_word` is valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_last`  out  1  current word is word WORDS-1 of its result.
- `count`  out  clog2(DEPTH+1)  FIFO occupancy, not counting the result in the shift register.
- `full`  out  1  `count==DEPTH`.
- `overflow`  out  1  sticky: a result was dropped.

## Operation

- Reset (`reset`=0 at an edge) clears the FIFO pointers and `count`, sets FSM=IDLE, and zeroes `out_valid`, `out_last`, `out_word`, `overflow` and `full`. Reset takes priority over every other event, including mid-result and with a full FIFO; a partially sent result is discarded.
- Push: `in_valid`=1 writes `Q` at the tail when `count<DEPTH` or when a pop happens in the same cycle. Otherwise `Q` is dropped and `overflow` sets; it stays set until reset.
- Pop: the head entry moves into the 256-bit shift register `sr`; word index `idx` is set to 0.
- FSM:
  - IDLE: `out_valid`=0. If `count>0`, pop and go to SEND.
  - SEND: `out_valid`=1, `out_word`=`sr[DATA_W-1 -: WORD_W]`, `out_last`=(`idx==WORDS-1`). On handshake (`out_valid&out_ready`):
    - If `idx<WORDS-1`: shift `sr` left by WORD_W and increment `idx`.
    - If `idx==WORDS-1` and `count>0`: pop the next entry and stay in SEND, with no bubble.
    - If `idx==WORDS-1` and `count==0`: go to IDLE.
- Without a handshake, `out_word`, `out_valid` and `out_last` hold stable.
- Simultaneous push and pop: `count` is unchanged and pointers wrap modulo DEPTH.
- Push into an empty FIFO while the FSM is in IDLE: the entry is written this edge and popped at the next edge. There is no bypass path.
- `out_ready` is ignored in IDLE.

## Timing

- Latency: `in_valid` sampled at edge k into an idle, empty block gives `out_valid`=1 with word 0 after edge k+1.
- Throughput: one word per cycle while `out_ready`=1, so one result per WORDS cycles.
- Effective buffering is DEPTH+1 results: the FIFO plus the shift register.
- `count`, `full` and `overflow` are registered and update at the push/pop edge.
- `out_last` is asserted together with `out_valid` on word WORDS-1 only.

## Test plan

- **Single result:** push `Q`=7aa790fb62f949ed3b4f3fce2d1b3c63c9f429ebabbbc258df59d4a4076784e0 with `out_ready`=1.
  - Required: words 7aa790fb, 62f949ed, 3b4f3fce, 2d1b3c63, c9f429eb, abbbc258, df59d4a4, 076784e0 on consecutive cycles.
  - `out_valid` rises after edge k+1; `out_last` is high only on 076784e0.
- **Backpressure:** same result with `out_ready` toggling 1,0,0,1,….
  - Required: each word is held unchanged while `out_ready`=0, and all eight words arrive in order with no duplicates.
- **Burst:** 10 back-to-back pushes (one per cycle) with `out_ready`=1.
  - Required: 80 words in push order with no idle cycle between results, `overflow`=0, peak `count`≤8.
- **Overflow:** DEPTH=16, `out_ready`=0, 20 consecutive pushes.
  - Required: result 1 is in `sr`, results 2–17 are in the FIFO, `count`=16, `full`=1, `overflow`=1.
  - After releasing `out_ready`: exactly 17 results are emitted, in order, and results 18–20 never appear.
- **Push while full, simultaneous with the final-word handshake:**
  - Required: the push is accepted, `count` stays 16, `overflow` stays 0.
- **Reset mid-operation:** assert `reset`=0 for one edge during word 3 of a result, with 5 entries queued.
  - Required: after that edge `out_valid`=0, `count`=0, `overflow`=0, `out_word`=0.
  - A subsequent push is emitted normally with correct latency.
